// File: rtl/ld19_pkg.sv
// Shared constants, register map and FSM state type for the LD19 packet receiver.
// Also provides the bytewise CRC8 step used to build the lookup ROM.
package ld19_pkg;

  localparam int          PKT_BYTES     = 47;
  localparam logic [7:0]  HDR_BYTE      = 8'h54;
  localparam logic [7:0]  VERLEN_BYTE   = 8'h2C;
  localparam logic [7:0]  CRC_POLY      = 8'h4D;
  localparam logic [5:0]  LAST_DATA_IDX = 6'(PKT_BYTES - 2);

  localparam logic [3:0]  ADDR_STATUS    = 4'd0;
  localparam logic [3:0]  ADDR_PKT_FIRST = 4'd1;
  localparam logic [3:0]  ADDR_PKT_LAST  = 4'd12;

  localparam int STAT_PKT_VALID = 0;
  localparam int STAT_OVERFLOW  = 1;
  localparam int STAT_IRQ_EN    = 2;

  typedef enum logic [1:0] {
    HUNT,
    VERLEN,
    PAYLOAD,
    CHECK
  } rx_state_t;

  // CRC of a single byte starting from zero; equals LUT[v] for an MSB-first CRC8.
  function automatic logic [7:0] crc8_byte(input logic [7:0] v);
    logic [7:0] c;
    c = v;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ld19_crc8_lut.sv
// 256x8 CRC8 (poly 0x4D) lookup ROM: crc_out = LUT[crc_in ^ data_in].
// Shared with the LD19 CRC Avalon slave.
module ld19_crc8_lut
  import ld19_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = crc8_byte(8'(i));
  end

  assign crc_out = rom[crc_in ^ data_in];

endmodule

// File: rtl/ld19_packet_rx.sv
// LD19 LiDAR packet receiver: header hunt, inline CRC8 check, Avalon-MM readable buffer.
// Optional macro LD19_PACKET_RX_IRQ_EN adds an irq output gated by status write bit2.
module ld19_packet_rx
  import ld19_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
`ifdef LD19_PACKET_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  rx_state_t  state, next_state;
  logic [5:0] byte_idx;
  logic [7:0] crc, crc_seed, crc_next;
  logic [7:0] cap_buf [PKT_BYTES-1];
  logic [7:0] rd_buf  [PKT_BYTES];

  logic       cap_we, commit, crc_err;
  logic [5:0] cap_idx;
  logic       is_hdr, is_verlen;

  logic       pkt_valid, overflow;
  logic [7:0] crc_err_cnt, drop_cnt;
  logic       reg_wr, rel_req, clr_req, load, drop;
  logic       irq_en_bit;
  logic [5:0] word_base;
  logic [31:0] rd_word;

  assign is_hdr    = (rx_data == HDR_BYTE);
  assign is_verlen = (rx_data == VERLEN_BYTE);

  assign reg_wr  = chipselect && write && (address == ADDR_STATUS);
  assign rel_req = reg_wr && writedata[0];
  assign clr_req = reg_wr && writedata[1];

  // A release in the same cycle frees the buffer before the commit lands.
  assign load = commit && (!pkt_valid || rel_req);
  assign drop = commit && pkt_valid && !rel_req;

  ld19_crc8_lut u_crc (
    .crc_in  (crc_seed),
    .data_in (rx_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (rx_valid) begin
      unique case (state)
        HUNT:    if (is_hdr) next_state = VERLEN;
        VERLEN:  if (is_verlen) next_state = PAYLOAD;
                 else if (!is_hdr) next_state = HUNT;
        PAYLOAD: if (byte_idx == LAST_DATA_IDX) next_state = CHECK;
        CHECK:   next_state = HUNT;
        default: next_state = HUNT;
      endcase
    end
  end

  // A header seen in HUNT or VERLEN (re)starts the packet with a zero CRC seed.
  always_comb begin
    cap_we   = 1'b0;
    cap_idx  = byte_idx;
    crc_seed = crc;
    commit   = 1'b0;
    crc_err  = 1'b0;
    if (rx_valid) begin
      unique case (state)
        HUNT: if (is_hdr) begin
          cap_we = 1'b1; cap_idx = 6'd0; crc_seed = 8'h00;
        end
        VERLEN: if (is_hdr) begin
          cap_we = 1'b1; cap_idx = 6'd0; crc_seed = 8'h00;
        end else if (is_verlen) begin
          cap_we = 1'b1; cap_idx = 6'd1;
        end
        PAYLOAD: cap_we = 1'b1;
        CHECK: begin
          commit  = (rx_data == crc);
          crc_err = (rx_data != crc);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc      <= 8'h00;
      byte_idx <= 6'd0;
      for (int i = 0; i < PKT_BYTES - 1; i++) cap_buf[i] <= 8'h00;
    end else begin
      if (cap_we) begin
        cap_buf[cap_idx] <= rx_data;
        crc              <= crc_next;
      end
      if (rx_valid && state == VERLEN && is_verlen) byte_idx <= 6'd2;
      else if (rx_valid && state == PAYLOAD)        byte_idx <= byte_idx + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PKT_BYTES; i++) rd_buf[i] <= 8'h00;
    end else if (load) begin
      for (int i = 0; i < PKT_BYTES - 1; i++) rd_buf[i] <= cap_buf[i];
      rd_buf[PKT_BYTES-1] <= rx_data;
    end
  end

  // Clear beats a same-cycle overflow or counter increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_valid   <= 1'b0;
      overflow    <= 1'b0;
      crc_err_cnt <= 8'h00;
      drop_cnt    <= 8'h00;
    end else begin
      if (load)         pkt_valid <= 1'b1;
      else if (rel_req) pkt_valid <= 1'b0;

      if (clr_req)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;

      if (clr_req)                              crc_err_cnt <= 8'h00;
      else if (crc_err && crc_err_cnt != 8'hFF) crc_err_cnt <= crc_err_cnt + 8'd1;

      if (clr_req)                        drop_cnt <= 8'h00;
      else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef LD19_PACKET_RX_IRQ_EN
  logic irq_en;
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:3];
  assign irq_en_bit   = irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (reg_wr) irq_en <= writedata[2];
      irq <= pkt_valid & irq_en;
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:2];
  assign irq_en_bit   = 1'b0;
`endif

  assign word_base = {address - ADDR_PKT_FIRST, 2'b00};

  always_comb begin
    rd_word = 32'h0;
    if (address == ADDR_STATUS) begin
      rd_word[31:24]          = drop_cnt;
      rd_word[23:16]          = crc_err_cnt;
      rd_word[STAT_IRQ_EN]    = irq_en_bit;
      rd_word[STAT_OVERFLOW]  = overflow;
      rd_word[STAT_PKT_VALID] = pkt_valid;
    end else if (address == ADDR_PKT_LAST) begin
      rd_word = {8'h00, rd_buf[46], rd_buf[45], rd_buf[44]};
    end else if (address < ADDR_PKT_LAST) begin
      rd_word = {rd_buf[word_base + 6'd3], rd_buf[word_base + 6'd2],
                 rd_buf[word_base + 6'd1], rd_buf[word_base]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                    readdata <= 32'h0;
    else if (chipselect && read)  readdata <= rd_word;
    else                          readdata <= 32'h0;
  end

endmodule

// File: doc/ld19_packet_rx.md
Name: ld19_packet_rx

Overview:
- Receive-side companion to the LD19 CRC Avalon slave.
- Takes the raw LD19 LiDAR byte stream from the UART receiver and hunts for the 0x54/0x2C header.
- Captures each 47-byte packet and checks its CRC8 inline, one byte at a time.
- Presents good packets to the Nios CPU as an Avalon-MM readable buffer, with status flags and error counters.

Parameters:
- PKT_BYTES, 47: total packet length including the CRC byte.
- HDR_BYTE, 8'h54: packet header byte.
- VERLEN_BYTE, 8'h2C: version/length byte expected directly after the header.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- address  in  4  Avalon word address.
- chipselect  in  1  Avalon chip select.
- read  in  1  Avalon read.
- write  in  1  Avalon write.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.

Behaviour:
- One clock; reset is synchronous and active-high. All state is sampled on posedge clk when reset=1.
- Reset values:
  - readdata=0, FSM=HUNT.
  - Byte counter=0, running crc=0.
  - pkt_valid=0, overflow=0, crc_err_cnt=0, drop_cnt=0.
  - Capture and readable buffers cleared.
- FSM (advances only on rx_valid):
  - HUNT: on byte==HDR_BYTE, store at index 0, crc<=LUT[0x00^byte], go to VERLEN. Otherwise stay.
  - VERLEN: on byte==VERLEN_BYTE, store at index 1, update crc, go to PAYLOAD. On byte==HDR_BYTE, restart as a new header and stay in VERLEN. Any other byte goes to HUNT.
  - PAYLOAD: store bytes 2..45 and update crc per byte. After index 45, go to CHECK.
  - CHECK: the byte is the received CRC.
    - Match: pulse commit, go to HUNT.
    - Mismatch: crc_err_cnt+1, go to HUNT, packet discarded.
- CRC: CRC8, polynomial 0x4D, init 0x00, no reflection, no final XOR. Update rule is crc <= LUT[crc ^ byte] over bytes 0..45.
- Commit:
  - If pkt_valid==0, copy the capture buffer to the readable buffer and set pkt_valid in the same cycle.
  - Else keep the old data, set overflow (sticky) and increment drop_cnt.
- Counters are 8-bit and saturate at 255.
- Register map. readdata is registered: 1-cycle latency, valid the cycle after the read. It is 0 when not addressed or not reading.
  - addr 0 read: {drop_cnt[31:24], crc_err_cnt[23:16], 14'b0, overflow[1], pkt_valid[0]}.
  - addr 0 write:
    - bit0=1: release buffer (pkt_valid<=0).
    - bit1=1: clear overflow and both counters.
    - bit2: irq enable (see Optional Feature).
  - addr 1..11 read: packet bytes 4(n-1)..4(n-1)+3, little-endian, byte 4(n-1) in [7:0].
  - addr 12 read: bytes 44..46 in [23:0], [31:24]=0.
  - addr 13..15 read: 0.
- Simultaneous events:
  - Release write and commit in the same cycle: release applies first, then the commit loads new data; pkt_valid stays 1 and drop_cnt does not change.
  - Clear write and counter increment in the same cycle: clear wins.
  - A CPU read during a commit returns pre-commit data. The readable buffer changes only at commit.
- rx_valid while pkt_valid=1 is still captured; there is no backpressure on the UART side.
- Reset mid-packet: the partial packet is lost and the FSM returns to HUNT.

Optional Feature:
- Macro: LD19_PACKET_RX_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - irq = registered (pkt_valid & irq_en), where irq_en is addr 0 write bit2; irq_en resets to 0.
  - Status read bit2 returns irq_en.
- Undefined:
  - No irq port; write bit2 is ignored and status read bit2 returns 0.

Decomposition:
- Package ld19_pkg holds:
  - Constants: HDR_BYTE, VERLEN_BYTE, PKT_BYTES, CRC_POLY=8'h4D, the register addresses, and the status bit positions.
  - FSM state enum: HUNT, VERLEN, PAYLOAD, CHECK.
- Sub-module ld19_crc8_lut: 256x8 combinational ROM, crc_out = LUT[crc_in ^ data_in]. The same table is reusable by the existing CRC block.

Test Plan:
- Reset, then read addr 0 → 0x00000000 on the cycle after the read.
- Valid packet (0x54, 0x2C, 44 random bytes, golden-model CRC) → pkt_valid=1. addr1 = {b3,b2,b1,0x54}… wait byte order: addr1 = {b3,b2,0x2C,0x54}; addr12 = {8'h00, crc, b45, b44}.
- Same packet with the CRC byte XORed by 0x01 → pkt_valid stays 0, crc_err_cnt=1.
- Stream 0x54, 0x54, 0x2C then the remainder with a correct CRC → packet accepted with byte0=0x54 (VERLEN re-sync).
- Two good packets without a release → second dropped, overflow=1, drop_cnt=1, buffer holds the first. Then write 0x1 in the cycle the third commits → pkt_valid=1, buffer holds the third.
- Assert reset after 20 payload bytes, then send a full good packet → only the full packet is committed, counters=0.
